// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
// Build option: define PIPE_SKID_EN to give every slot a skid register, so that
// in_ready comes straight from a flop.
package pipe_stage_pkg;

  // Default widths for a MIPS inter-stage latch
  localparam int PIPE_CTRL_W     = 9;
  localparam int PIPE_DATA_W     = 32;
  localparam int PIPE_NUM_DATA   = 2;
  localparam int PIPE_RD_W       = 5;
  localparam int PIPE_CNT_W      = 16;
  localparam int PIPE_MAX_STAGES = 4;

  // One beat as it travels down the chain. Packing order is ctrl, data, rd
  // (MSB to LSB), and data word 0 sits in the LSBs of the data field.
  typedef struct packed {
    logic [PIPE_CTRL_W-1:0]               ctrl;
    logic [PIPE_NUM_DATA*PIPE_DATA_W-1:0] data;
    logic [PIPE_RD_W-1:0]                 rd;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid/ready handshake slot of the pipeline register chain.
// PIPE_SKID_EN defined: main + skid register; up_ready is registered (= !skid_valid),
// so there is no combinational path from dn_ready to up_ready.
// PIPE_SKID_EN undefined: a single register; up_ready = !valid || dn_ready.
// flush clears every valid bit at the next edge and takes priority over load and drain.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter type payload_t = pipe_payload_t
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     up_valid,
  output logic     up_ready,
  input  payload_t up_payload,
  output logic     dn_valid,
  input  logic     dn_ready,
  output payload_t dn_payload
);

  logic     main_valid_reg;
  logic     main_valid_next;
  payload_t main_payload_reg;
  payload_t main_payload_next;

`ifdef PIPE_SKID_EN

  logic     skid_valid_reg;
  logic     skid_valid_next;
  payload_t skid_payload_reg;
  payload_t skid_payload_next;

  // Accept whenever the skid register is free; this is a pure flop output
  assign up_ready = !skid_valid_reg;

  // Next-state: main refills from skid first (keeps order), else from upstream;
  // a beat arriving while main is stalled parks in skid
  always_comb begin
    main_valid_next   = main_valid_reg;
    main_payload_next = main_payload_reg;
    skid_valid_next   = skid_valid_reg;
    skid_payload_next = skid_payload_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || dn_ready) begin
      if (skid_valid_reg) begin
        main_valid_next   = 1'b1;
        main_payload_next = skid_payload_reg;
        skid_valid_next   = 1'b0;
      end else begin
        main_valid_next = up_valid;
        if (up_valid) begin
          main_payload_next = up_payload;
        end
      end
    end else if (up_valid && !skid_valid_reg) begin
      skid_valid_next   = 1'b1;
      skid_payload_next = up_payload;
    end
  end

  // Skid register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_reg   <= 1'b0;
      skid_payload_reg <= '0;
    end else begin
      skid_valid_reg   <= skid_valid_next;
      skid_payload_reg <= skid_payload_next;
    end
  end

`else

  // Free when empty or when the held beat leaves this same cycle
  assign up_ready = !main_valid_reg || dn_ready;

  // Next-state: load on a handshake, go empty when draining with nothing new;
  // the payload of an empty slot keeps its last value
  always_comb begin
    main_valid_next   = main_valid_reg;
    main_payload_next = main_payload_reg;
    if (flush) begin
      main_valid_next = 1'b0;
    end else if (up_ready) begin
      main_valid_next = up_valid;
      if (up_valid) begin
        main_payload_next = up_payload;
      end
    end
  end

`endif

  // Main register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg   <= 1'b0;
      main_payload_reg <= '0;
    end else begin
      main_valid_reg   <= main_valid_next;
      main_payload_reg <= main_payload_next;
    end
  end

  assign dn_valid   = main_valid_reg;
  assign dn_payload = main_payload_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register for the MIPS core (IF/ID .. MEM/WB).
// STAGES chained handshake slots carry {ctrl, data words, rd}. out_ctrl is masked to 0
// whenever no beat is presented, so a bubble cannot trigger a write-back or memory op.
// stall_cnt is a saturating count of cycles with out_valid && !out_ready.
// Build option: PIPE_SKID_EN (see pipe_stage_slot) doubles the per-slot capacity and
// registers in_ready.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int NUM_DATA = PIPE_NUM_DATA,
  parameter int RD_W     = PIPE_RD_W,
  parameter int STAGES   = 1,
  parameter int CNT_W    = PIPE_CNT_W
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd,
  output logic [CNT_W-1:0]           stall_cnt
);

  // Same layout as pipe_payload_t, sized by this instance's parameters
  typedef struct packed {
    logic [CTRL_W-1:0]          ctrl;
    logic [NUM_DATA*DATA_W-1:0] data;
    logic [RD_W-1:0]            rd;
  } payload_t;

  // Element k is the upstream side of slot k; element STAGES is the output port
  logic [STAGES:0] valid_chain;
  logic [STAGES:0] ready_chain;
  payload_t        payload_chain [0:STAGES];
  payload_t        out_payload;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign valid_chain[0]      = in_valid;
  assign payload_chain[0]    = {in_ctrl, in_data, in_rd};
  assign ready_chain[STAGES] = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
      pipe_stage_slot #(
        .payload_t (payload_t)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (valid_chain[gi]),
        .up_ready   (ready_chain[gi]),
        .up_payload (payload_chain[gi]),
        .dn_valid   (valid_chain[gi+1]),
        .dn_ready   (ready_chain[gi+1]),
        .dn_payload (payload_chain[gi+1])
      );
    end
  endgenerate

  // Nothing is taken while a flush is in progress
  assign in_ready = ready_chain[0] && !flush;

  assign out_payload = payload_chain[STAGES];
  assign out_valid   = valid_chain[STAGES];
  assign out_ctrl    = out_valid ? out_payload.ctrl : '0;
  assign out_data    = out_payload.data;
  assign out_rd      = out_payload.rd;

  // Count stalled output cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances with STAGES=1..4 (instance 0 uses CNT_W=4).
// Directed tests run on the STAGES=3 instance; random traffic runs on all of them
// against a queue-based reference of the accepted beats.
module tb_pipe_stage_reg;

  localparam int NI = 4;
  localparam int D  = 2;   // STAGES=3 instance
  localparam int BW = 78;  // 9 ctrl + 64 data + 5 rd
`ifdef PIPE_SKID_EN
  localparam int CAP3 = 6;
`else
  localparam int CAP3 = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush     [NI];
  logic        in_valid  [NI];
  logic [8:0]  in_ctrl   [NI];
  logic [63:0] in_data   [NI];
  logic [4:0]  in_rd     [NI];
  logic        out_ready [NI];
  wire         in_ready  [NI];
  wire         out_valid [NI];
  wire  [8:0]  out_ctrl  [NI];
  wire  [63:0] out_data  [NI];
  wire  [4:0]  out_rd    [NI];
  wire  [15:0] stall_cnt [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int CW = (gi == 0) ? 4 : 16;
      wire [CW-1:0] sc;
      pipe_stage_reg #(
        .CTRL_W(9), .DATA_W(32), .NUM_DATA(2), .RD_W(5), .STAGES(gi + 1), .CNT_W(CW)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush[gi]),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_ctrl   (in_ctrl[gi]),
        .in_data   (in_data[gi]),
        .in_rd     (in_rd[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_ctrl  (out_ctrl[gi]),
        .out_data  (out_data[gi]),
        .out_rd    (out_rd[gi]),
        .stall_cnt (sc)
      );
      assign stall_cnt[gi] = 16'(sc);
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] q [NI][$];   // accepted, not yet delivered beats
  int delivered [NI];

  typedef struct {
    logic          vin;
    logic [BW-1:0] beat;
    logic          exp_ready;
    logic          exp_valid;
    logic [BW-1:0] exp_beat;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d act=%0h exp=%0h", name, inst, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int k);
    logic [8:0]  c;
    logic [63:0] d;
    logic [4:0]  r;
    c = 9'h1A5 ^ 9'(k);
    d = {32'(32'hD000_0000 + k), 32'(32'hA000_0000 + k)};
    r = 5'(7 + k);
    return {c, d, r};
  endfunction

  function automatic logic [BW-1:0] out_beat(input int i);
    return {out_ctrl[i], out_data[i], out_rd[i]};
  endfunction

  task automatic drive(input int i, input logic v, input logic [BW-1:0] b);
    in_valid[i] = v;
    {in_ctrl[i], in_data[i], in_rd[i]} = b;
  endtask

  // Reference: handshakes push/pop an in-order queue; bubbles must show ctrl=0
  task automatic sample_all();
    logic [BW-1:0] e;
    for (int i = 0; i < NI; i++) begin
      if (in_valid[i] && in_ready[i]) q[i].push_back({in_ctrl[i], in_data[i], in_rd[i]});
      if (out_valid[i] && out_ready[i]) begin
        delivered[i]++;
        if (q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected inst=%0d act=%0h exp=none", i, out_beat(i));
        end else begin
          e = q[i].pop_front();
          chk("out_beat", i, out_beat(i), e);
        end
      end
      if (!out_valid[i]) chk("ctrl_mask", i, out_ctrl[i], 0);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      flush[i] = 1'b0;
      out_ready[i] = 1'b1;
      drive(i, 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      delivered[i] = 0;
    end
  endtask

  task automatic step(); // sample away from the edge, then let the edge happen
    #1;
    sample_all();
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog inst=-1 act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int stall_before;
    logic [BW-1:0] first_out;
    logic acc_prev [NI];
    logic prev_stall [NI];
    logic [BW-1:0] prev_out [NI];

    // Streaming table for STAGES=3: accepted at edge r, visible after edge r+2
    for (int r = 0; r < 11; r++) begin
      tbl[r].vin       = (r < 8);
      tbl[r].beat      = (r < 8) ? mk_beat(r) : '0;
      tbl[r].exp_ready = 1'b1;
      tbl[r].exp_valid = (r >= 2) && (r - 2 < 8);
      tbl[r].exp_beat  = tbl[r].exp_valid ? mk_beat(r - 2) : '0;
    end

    idle_all();
    for (int i = 0; i < NI; i++) delivered[i] = 0;

    // Reset state
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", i, out_valid[i], 0);
      chk("rst_out_ctrl", i, out_ctrl[i], 0);
      chk("rst_stall_cnt", i, stall_cnt[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, one beat per cycle, no gaps
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      drive(D, tbl[r].vin, tbl[r].beat);
      #1;
      chk("stream_in_ready", D, in_ready[D], tbl[r].exp_ready);
      sample_all();
      @(posedge clk);
      #1;
      chk("stream_out_valid", D, out_valid[D], tbl[r].exp_valid);
      if (tbl[r].exp_valid) chk("stream_out_beat", D, out_beat(D), tbl[r].exp_beat);
      else chk("stream_out_ctrl", D, out_ctrl[D], 0);
      $display("stream row %0d out_valid=%0b out_ctrl=%0h", r, out_valid[D], out_ctrl[D]);
    end

    // Backpressure: 8 stalled cycles, output valid for the last 5
    do_reset();
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready[D] = 1'b0;
      drive(D, 1'b1, mk_beat(100 + nb));
      #1;
      if (in_valid[D] && in_ready[D]) nb++;
      chk("bp_out_valid", D, out_valid[D], (c >= 3));
      if (c >= 3) chk("bp_out_hold", D, out_beat(D), mk_beat(100));
      sample_all();
      @(posedge clk);
    end
    #1;
    chk("bp_stall_cnt", D, stall_cnt[D], 5);
    chk("bp_capacity", D, nb, CAP3);
    chk("bp_in_ready_low", D, in_ready[D], 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready[D] = 1'b1;
      drive(D, 1'b0, '0);
      step();
    end
    chk("bp_delivered", D, delivered[D], CAP3);
    chk("bp_queue_empty", D, q[D].size(), 0);
    $display("backpressure accepted=%0d delivered=%0d", nb, delivered[D]);

    // Flush with two beats in flight and a third presented
    stall_before = stall_cnt[D];
    @(negedge clk); drive(D, 1'b1, mk_beat(200)); step();
    @(negedge clk); drive(D, 1'b1, mk_beat(201)); step();
    @(negedge clk);
    flush[D] = 1'b1;
    drive(D, 1'b1, mk_beat(202));
    #1;
    chk("flush_in_ready", D, in_ready[D], 0);
    sample_all();
    q[D].delete();          // everything in flight is dropped
    @(posedge clk);
    #1;
    chk("flush_out_valid", D, out_valid[D], 0);
    chk("flush_out_ctrl", D, out_ctrl[D], 0);
    delivered[D] = 0;
    @(negedge clk);
    flush[D] = 1'b0;
    drive(D, 1'b1, mk_beat(203));
    #1;
    chk("post_flush_in_ready", D, in_ready[D], 1);
    sample_all();
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(D, 1'b0, '0);
      step();
    end
    chk("post_flush_delivered", D, delivered[D], 1);
    chk("flush_stall_cnt", D, stall_cnt[D], stall_before);
    $display("flush delivered_after=%0d", delivered[D]);

    // Saturation: 4-bit counter held in stall for 20 cycles
    @(negedge clk);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, mk_beat(300));
    step();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(0, 1'b0, '0);
      step();
    end
    #1;
    chk("sat_stall_cnt", 0, stall_cnt[0], 16'hF);
    @(negedge clk);
    out_ready[0] = 1'b1;
    step();
    $display("saturation stall_cnt=%0h", stall_cnt[0]);

    // Async reset while beats are flowing and stalled
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready[D] = 1'b0;
      drive(D, 1'b1, mk_beat(400 + c));
      step();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", D, out_valid[D], 0);
    chk("arst_out_ctrl", D, out_ctrl[D], 0);
    chk("arst_stall_cnt", D, stall_cnt[D], 0);
    chk("arst_stall_cnt_sat", 0, stall_cnt[0], 0);
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      delivered[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", D, in_ready[D], 1);
    drive(D, 1'b0, '0);
    out_ready[D] = 1'b1;
    $display("async reset done");

    // Random valid/ready on all four depths
    for (int i = 0; i < NI; i++) begin
      acc_prev[i] = 1'b0;
      prev_stall[i] = 1'b0;
      prev_out[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!in_valid[i] || acc_prev[i]) begin
          in_valid[i] = ($urandom_range(0, 99) < 70);
          in_ctrl[i]  = 9'($urandom);
          in_data[i]  = {$urandom, $urandom};
          in_rd[i]    = 5'($urandom);
        end
        out_ready[i] = ($urandom_range(0, 99) < 60);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        if (prev_stall[i]) begin
          chk("hold_valid", i, out_valid[i], 1);
          chk("hold_beat", i, out_beat(i), prev_out[i]);
        end
        acc_prev[i]   = in_valid[i] && in_ready[i];
        prev_stall[i] = out_valid[i] && !out_ready[i];
        prev_out[i]   = out_beat(i);
      end
      sample_all();
      @(posedge clk);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idle_all();
      step();
    end
    for (int i = 0; i < NI; i++) begin
      chk("rand_drained", i, q[i].size(), 0);
      $display("random inst=%0d delivered=%0d", i, delivered[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
